// File: rtl/seg7_pkg.sv
// Shared constants and BCD-to-segment decoding for the multiplexed 7-segment display driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Codes 10..15 are not digits and are shown dark rather than as hex glyphs.
    function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        case (bcd)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_blank_mask.sv
// Leading-zero mask: bit i is set when digit i and every more significant digit are zero.
// Digit 0 is never masked so a zero value still shows a single "0".
module seg7_blank_mask
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [NUM_DIGITS-1:0][BCD_W-1:0] digits,
    input  logic                             enable,
    output logic [NUM_DIGITS-1:0]            mask
);

    logic zero_above;

    always_comb begin
        mask       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (digits[i] == '0);
            mask[i]    = enable && zero_above;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with leading-zero blanking, guard interval,
// 16-level PWM brightness and frame-synchronous (tear-free) display updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 10000,
    parameter int GUARD      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        load,
    input  logic                        blank_lz,
    input  logic [3:0]                  brightness,
    output logic [6:0]                  segments,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]                   prescaler;
    logic [IW-1:0]                   idx;
    logic [3:0]                      pwm_cnt;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] shadow;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] disp;
    logic [NUM_DIGITS-1:0]           blank_mask;

    logic slot_end;
    logic frame_wrap;
    logic lit;

    seg7_blank_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_blank_mask (
        .digits(disp),
        .enable(blank_lz),
        .mask  (blank_mask)
    );

    assign slot_end   = (prescaler == PW'(SCAN_DIV - 1));
    assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));
    assign lit        = (prescaler >= PW'(GUARD)) && (pwm_cnt <= brightness) && !blank_mask[idx];

    // Scan timing: prescaler within a slot, idx across slots, free-running PWM phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            idx        <= '0;
            pwm_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 4'd1;
            frame_done <= frame_wrap;
            if (slot_end) begin
                prescaler <= '0;
                idx       <= frame_wrap ? '0 : idx + IW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // A load landing on the boundary cycle goes straight to disp so it is not delayed a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            disp   <= '0;
        end else begin
            if (load) begin
                shadow <= digits_in;
            end
            if (frame_wrap) begin
                disp <= load ? digits_in : shadow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segments <= '0;
            digit_en <= '0;
        end else begin
            digit_en <= lit ? (NUM_DIGITS'(1) << idx) : '0;
            segments <= lit ? bcd_to_seg(disp[idx]) : SEG_BLANK;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the seconds/digit counters. It latches a packed multi-digit BCD value and time-multiplexes it onto one shared 7-segment bus with one-hot digit enables. It adds leading-zero blanking, an anti-ghosting guard interval and 16-level PWM brightness. Tearing-free updates are applied only at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 10000, clk cycles per digit slot (1 kHz/digit at 10 MHz); must be > GUARD
GUARD, 16, cycles at the start of each slot during which all digits are dark

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
digits_in  in  4*NUM_DIGITS  packed BCD; nibble 0 = least significant digit
load  in  1  single-cycle strobe; captures digits_in into shadow register
blank_lz  in  1  1 = blank leading zeros
brightness  in  4  PWM duty; on-time = (brightness+1)/16 of the non-guard slot time
segments  out  7  active-high segments {g,f,e,d,c,b,a}, registered
digit_en  out  NUM_DIGITS  one-hot active-high digit select, registered
frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: prescaler=0, idx=0, pwm_cnt=0, shadow=0, disp=0, segments=0, digit_en=0, frame_done=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances. idx wraps from NUM_DIGITS-1 to 0.
- frame_done is registered. It pulses high for exactly one cycle, in the cycle after idx wraps to 0.
- pwm_cnt is a 4-bit free-running counter that increments every clk.
- lit = (prescaler >= GUARD) && (pwm_cnt <= brightness) && !blank(idx).
- Outputs are registered with 1-cycle latency from internal state:
  - digit_en <= lit ? (1 << idx) : 0.
  - segments <= lit ? decode(disp[idx]) : 0.
- Nibble values 10..15 decode to all-off segments. digit_en is still driven for these values.
- Load and update rules:
  - load=1 sets shadow <= digits_in.
  - At the frame boundary (idx wraps to 0), disp <= shadow.
  - If load coincides with the boundary cycle, disp <= digits_in directly, bypassing shadow. Shadow also updates.
- Leading-zero blanking:
  - Applies only when blank_lz=1.
  - Digit i is blanked iff disp[i]==0 and every digit j>i also ==0.
  - Digit 0 is never blanked.
  - blank_lz=0 blanks nothing.
- brightness and blank_lz are sampled live every cycle. No latching.
- Reset asserted mid-frame returns all state to reset values on the next edge. No partial frame is emitted.
- Exactly zero or one bit of digit_en is ever high.

Decomposition:
- Package seg7_pkg holds:
  - BCD width localparam (4).
  - Segment-pattern constants for 0..9 plus SEG_BLANK.
  - A function bcd_to_seg().
- The existing seg7 decoder is not reused, because of the 10..15 blanking rule.
- One sub-module is natural: seg7_blank_mask (combinational, NUM_DIGITS-parameterised leading-zero mask). Everything else stays in the top.

Test Plan:
- Reset: hold reset 3 cycles mid-scan -> segments=0, digit_en=0, frame_done=0; first slot after release selects digit 0.
- Scan, leading-zero blanking (NUM_DIGITS=4, SCAN_DIV=8, GUARD=1, brightness=15, blank_lz=0):
  - Load 0x1234 -> after first frame_done, slots show digit0=4 (0x66), digit1=3 (0x4F), digit2=2 (0x5B), digit3=1 (0x06).
  - Each digit is on for 7 of 8 cycles. frame_done repeats every 32 cycles.
- Leading-zero blanking: blank_lz=1, load 0x0040 -> digits 3 and 2 dark, digit1=4, digit0=0 (0x3F) lit. Load 0x0000 -> only digit0 shows 0.
- Tear-free update:
  - Load 0x5678 mid-frame -> the current frame keeps the old value; 0x5678 appears from the next frame.
  - Load asserted on the boundary cycle -> the new value is shown in that frame.
- Brightness: brightness=0 -> digit_en high 1 cycle in 16 during the non-guard window; brightness=7 -> 8 of 16.
- Invalid BCD: load 0x00A0 with blank_lz=0 -> digit1 slot has digit_en asserted, segments=0.
